reg_file_mp: RTL and testbench

//   Parametrised multi-port integer register file for the RISC-V core: NRD combinational

---
 rtl/reg_file_mp_if.sv | 28 ++
 rtl/reg_file_mp.sv | 64 ++++++
 tb/tb_reg_file_mp.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_mp_if.sv
// reg_file_mp_if: read/write/issue bus of the multi-port register file and its scoreboard view.
interface reg_file_mp_if #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int NRD   = 4
);
   localparam int AW = $clog2(NREGS);
   logic [NRD*AW-1:0]   rd_addr;
   logic [NRD*XLEN-1:0] rd_data;
   logic [NRD-1:0]      rd_busy;
   logic                we0;
   logic [AW-1:0]       wa0;
   logic [XLEN-1:0]     wd0;
   logic                we1;
   logic [AW-1:0]       wa1;
   logic [XLEN-1:0]     wd1;
   logic                iss_valid;
   logic [AW-1:0]       iss_addr;
   logic [NREGS-1:0]    busy_vec;
   modport master (
      output rd_addr, we0, wa0, wd0, we1, wa1, wd1, iss_valid, iss_addr,
      input  rd_data, rd_busy, busy_vec
   );
   modport slave (
      input  rd_addr, we0, wa0, wd0, we1, wa1, wd1, iss_valid, iss_addr,
      output rd_data, rd_busy, busy_vec
   );
endinterface

// File: rtl/reg_file_mp.sv
// reg_file_mp: NRD-read / 2-write integer register file with x0 tied to zero, optional bypass and busy scoreboard.
module reg_file_mp #(
   parameter int XLEN   = 32,
   parameter int NREGS  = 32,
   parameter int NRD    = 4,
   parameter int BYPASS = 1
) (
   input logic         clock,
   input logic         reset,
   reg_file_mp_if.slave bus
);
   localparam int AW = $clog2(NREGS);
   logic [XLEN-1:0]     regs [NREGS];
   logic [NREGS-1:0]    busy_q;
   logic [NREGS-1:0]    busy_nxt;
   logic [NRD*XLEN-1:0] rd_data_w;
   logic [NRD-1:0]      rd_busy_w;
   function automatic logic valid_addr(logic [AW-1:0] a);
      return a != '0 && int'(a) < NREGS;
   endfunction
   // Forwarding is suppressed while in reset so reads stay at zero.
   function automatic logic fwd1(logic [AW-1:0] a);
      return BYPASS != 0 && reset && bus.we1 && bus.wa1 == a;
   endfunction
   function automatic logic fwd0(logic [AW-1:0] a);
      return BYPASS != 0 && reset && bus.we0 && bus.wa0 == a;
   endfunction
   function automatic logic [XLEN-1:0] read_data(logic [AW-1:0] a);
      return !valid_addr(a) ? '0 : fwd1(a) ? bus.wd1 : fwd0(a) ? bus.wd0 : regs[a];
   endfunction
   function automatic logic read_busy(logic [AW-1:0] a);
      return valid_addr(a) && !fwd1(a) && !fwd0(a) && busy_q[a];
   endfunction
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
         busy_q <= '0;
      end else begin
         if (bus.we0 && valid_addr(bus.wa0)) regs[bus.wa0] <= bus.wd0;
         if (bus.we1 && valid_addr(bus.wa1)) regs[bus.wa1] <= bus.wd1;
         busy_q <= busy_nxt;
      end
   end
   // Issue beats writeback so a re-issued destination stays busy.
   always_comb begin
      busy_nxt = '0;
      for (int i = 1; i < NREGS; i++) begin
         busy_nxt[i] = (bus.iss_valid && int'(bus.iss_addr) == i) ? 1'b1 :
                       ((bus.we0 && int'(bus.wa0) == i) || (bus.we1 && int'(bus.wa1) == i)) ? 1'b0 :
                       busy_q[i];
      end
   end
   always_comb begin
      rd_data_w = '0;
      rd_busy_w = '0;
      for (int k = 0; k < NRD; k++) begin
         rd_data_w[k*XLEN +: XLEN] = read_data(bus.rd_addr[k*AW +: AW]);
         rd_busy_w[k]              = read_busy(bus.rd_addr[k*AW +: AW]);
      end
   end
   assign bus.rd_data  = rd_data_w;
   assign bus.rd_busy  = rd_busy_w;
   assign bus.busy_vec = busy_q;
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed and randomized checks of reg_file_mp (BYPASS=1 and BYPASS=0 side by side) against an array model.
module tb_reg_file_mp;
   localparam int XLEN = 32, NREGS = 32, NRD = 4, AW = 5;
   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;
   logic [NRD*AW-1:0] rd_addr;
   logic we0, we1, iss_valid;
   logic [AW-1:0] wa0, wa1, iss_addr;
   logic [XLEN-1:0] wd0, wd1;
   int checks = 0;
   int failures = 0;
   logic [XLEN-1:0] m_reg [NREGS];
   logic [NREGS-1:0] m_busy;
   reg_file_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) b1 ();
   reg_file_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) b0 ();
   assign b1.rd_addr = rd_addr;   assign b0.rd_addr = rd_addr;
   assign b1.we0 = we0;           assign b0.we0 = we0;
   assign b1.wa0 = wa0;           assign b0.wa0 = wa0;
   assign b1.wd0 = wd0;           assign b0.wd0 = wd0;
   assign b1.we1 = we1;           assign b0.we1 = we1;
   assign b1.wa1 = wa1;           assign b0.wa1 = wa1;
   assign b1.wd1 = wd1;           assign b0.wd1 = wd1;
   assign b1.iss_valid = iss_valid; assign b0.iss_valid = iss_valid;
   assign b1.iss_addr = iss_addr; assign b0.iss_addr = iss_addr;
   reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1)) u_byp (.clock(clock), .reset(reset), .bus(b1));
   reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(0)) u_nob (.clock(clock), .reset(reset), .bus(b0));
   function automatic logic [XLEN-1:0] d1(int k);
      return b1.rd_data[k*XLEN +: XLEN];
   endfunction
   function automatic logic [XLEN-1:0] d0(int k);
      return b0.rd_data[k*XLEN +: XLEN];
   endfunction
   function automatic logic [NRD*AW-1:0] ports(int a0, int a1, int a2, int a3);
      return {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
   endfunction
   function automatic logic [XLEN-1:0] exp_data(logic [AW-1:0] a, bit byp);
      if (a == 0) return '0;
      if (byp && reset && we1 && wa1 == a) return wd1;
      if (byp && reset && we0 && wa0 == a) return wd0;
      return m_reg[a];
   endfunction
   function automatic logic exp_busy(logic [AW-1:0] a, bit byp);
      if (a == 0) return 1'b0;
      if (byp && reset && ((we1 && wa1 == a) || (we0 && wa0 == a))) return 1'b0;
      return m_busy[a];
   endfunction
   function automatic logic [AW-1:0] rand_addr();
      return ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, 31));
   endfunction
   task automatic idle();
      we0 = 0; we1 = 0; iss_valid = 0;
      wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; iss_addr = '0;
   endtask
   task automatic model_reset();
      for (int i = 0; i < NREGS; i++) m_reg[i] = '0;
      m_busy = '0;
   endtask
   task automatic tick();
      @(posedge clock);
      if (reset) begin
         if (we0 && wa0 != 0) m_reg[wa0] = wd0;
         if (we1 && wa1 != 0) m_reg[wa1] = wd1;
         if (we0) m_busy[wa0] = 1'b0;
         if (we1) m_busy[wa1] = 1'b0;
         if (iss_valid) m_busy[iss_addr] = 1'b1;
         m_busy[0] = 1'b0;
      end
      #1;
   endtask

   task automatic test_reset();
      idle();
      rd_addr = ports(1, 2, 9, 0);
      #2;
      checks++;
      if (b1.busy_vec !== '0 || b0.busy_vec !== '0) begin
         failures++; $display("FAIL reset_busy got=%h/%h exp=0", b1.busy_vec, b0.busy_vec);
      end
      @(negedge clock);
      reset = 1;
      #1;
      we0 = 1; wa0 = 1; wd0 = 32'h11;
      we1 = 1; wa1 = 2; wd1 = 32'h22;
      iss_valid = 1; iss_addr = 9;
      tick();
      idle();
      #1;
      checks++;
      if (d0(0) !== 32'h11 || d0(1) !== 32'h22 || b0.busy_vec[9] !== 1'b1) begin
         failures++; $display("FAIL load_before_reset got=%h %h busy9=%b exp=11 22 1", d0(0), d0(1), b0.busy_vec[9]);
      end
      #1;
      reset = 0;
      model_reset();
      #1;
      for (int k = 0; k < NRD; k++) begin
         checks++;
         if (d1(k) !== '0 || d0(k) !== '0 || b1.rd_busy[k] !== 1'b0 || b0.rd_busy[k] !== 1'b0) begin
            failures++; $display("FAIL async_reset_port%0d got=%h/%h busy=%b/%b exp=0", k, d1(k), d0(k), b1.rd_busy[k], b0.rd_busy[k]);
         end
      end
      checks++;
      if (b1.busy_vec !== '0 || b0.busy_vec !== '0) begin
         failures++; $display("FAIL async_reset_busy got=%h/%h exp=0", b1.busy_vec, b0.busy_vec);
      end
      we1 = 1; wa1 = 1; wd1 = 32'h99;
      iss_valid = 1; iss_addr = 5;
      #1;
      checks++;
      if (d1(0) !== '0) begin
         failures++; $display("FAIL reset_no_bypass got=%h exp=0", d1(0));
      end
      @(posedge clock);
      #1;
      checks++;
      if (d1(0) !== '0 || d0(0) !== '0 || b1.busy_vec !== '0) begin
         failures++; $display("FAIL reset_ignores_write got=%h/%h busy=%h exp=0", d1(0), d0(0), b1.busy_vec);
      end
      idle();
      @(negedge clock);
      reset = 1;
      #1;
   endtask

   task automatic test_x0_write();
      we0 = 1; wa0 = 0; wd0 = 32'h14;
      we1 = 1; wa1 = 1; wd1 = 32'h1E;
      rd_addr = ports(0, 1, 0, 1);
      #1;
      checks++;
      if (d1(1) !== 32'h1E || d0(1) !== 32'h0) begin
         failures++; $display("FAIL x1_same_cycle got=%h/%h exp=1e/0", d1(1), d0(1));
      end
      checks++;
      if (d1(0) !== 32'h0 || d0(0) !== 32'h0) begin
         failures++; $display("FAIL x0_same_cycle got=%h/%h exp=0", d1(0), d0(0));
      end
      tick();
      idle();
      #1;
      checks++;
      if (d1(1) !== 32'h1E || d0(1) !== 32'h1E || d1(0) !== 32'h0 || d0(0) !== 32'h0) begin
         failures++; $display("FAIL x0_x1_next_cycle got=%h %h / %h %h exp=0 1e", d1(0), d1(1), d0(0), d0(1));
      end
   endtask

   task automatic test_dual_write();
      we0 = 1; wa0 = 5; wd0 = 32'hAAAA;
      we1 = 1; wa1 = 5; wd1 = 32'h5555;
      rd_addr = ports(5, 0, 0, 0);
      #1;
      checks++;
      if (d1(0) !== 32'h5555) begin
         failures++; $display("FAIL same_addr_bypass got=%h exp=5555", d1(0));
      end
      tick();
      idle();
      #1;
      checks++;
      if (d1(0) !== 32'h5555 || d0(0) !== 32'h5555) begin
         failures++; $display("FAIL same_addr_port1_wins got=%h/%h exp=5555", d1(0), d0(0));
      end
      we0 = 1; wa0 = 6; wd0 = 32'h66;
      we1 = 1; wa1 = 7; wd1 = 32'h77;
      rd_addr = ports(6, 7, 5, 0);
      tick();
      idle();
      #1;
      checks++;
      if (d0(0) !== 32'h66 || d0(1) !== 32'h77 || d1(0) !== 32'h66 || d1(1) !== 32'h77 || d0(2) !== 32'h5555) begin
         failures++; $display("FAIL two_addr_commit got=%h %h %h exp=66 77 5555", d0(0), d0(1), d0(2));
      end
   endtask

   task automatic test_scoreboard();
      iss_valid = 1; iss_addr = 3;
      rd_addr = ports(3, 3, 0, 0);
      #1;
      checks++;
      if (b1.rd_busy[0] !== 1'b0 || b0.busy_vec[3] !== 1'b0) begin
         failures++; $display("FAIL busy_before_edge got=%b/%b exp=0", b1.rd_busy[0], b0.busy_vec[3]);
      end
      tick();
      idle();
      #1;
      checks++;
      if (b1.busy_vec[3] !== 1'b1 || b0.busy_vec[3] !== 1'b1 || b1.rd_busy[0] !== 1'b1 || b0.rd_busy[0] !== 1'b1) begin
         failures++; $display("FAIL issue_sets_busy got=%b%b rd=%b%b exp=11 11", b1.busy_vec[3], b0.busy_vec[3], b1.rd_busy[0], b0.rd_busy[0]);
      end
      we0 = 1; wa0 = 3; wd0 = 32'h32;
      #1;
      checks++;
      if (d1(0) !== 32'h32 || b1.rd_busy[0] !== 1'b0) begin
         failures++; $display("FAIL wb_bypass got=%h busy=%b exp=32 0", d1(0), b1.rd_busy[0]);
      end
      checks++;
      if (d0(0) !== 32'h0 || b0.rd_busy[0] !== 1'b1) begin
         failures++; $display("FAIL wb_nobypass got=%h busy=%b exp=0 1", d0(0), b0.rd_busy[0]);
      end
      tick();
      idle();
      #1;
      checks++;
      if (b1.busy_vec[3] !== 1'b0 || b0.busy_vec[3] !== 1'b0 || d0(0) !== 32'h32 || b0.rd_busy[0] !== 1'b0) begin
         failures++; $display("FAIL wb_clears_busy got=%b%b data=%h exp=00 32", b1.busy_vec[3], b0.busy_vec[3], d0(0));
      end
   endtask

   task automatic test_issue_and_write();
      iss_valid = 1; iss_addr = 4;
      we1 = 1; wa1 = 4; wd1 = 32'h44;
      rd_addr = ports(4, 0, 0, 0);
      tick();
      idle();
      #1;
      checks++;
      if (b1.busy_vec[4] !== 1'b1 || b0.busy_vec[4] !== 1'b1 || d0(0) !== 32'h44) begin
         failures++; $display("FAIL issue_beats_wb got=%b%b data=%h exp=11 44", b1.busy_vec[4], b0.busy_vec[4], d0(0));
      end
      iss_valid = 1; iss_addr = 0;
      tick();
      idle();
      #1;
      checks++;
      if (b1.busy_vec[0] !== 1'b0 || b0.busy_vec[0] !== 1'b0 || b1.rd_busy[1] !== 1'b0) begin
         failures++; $display("FAIL issue_x0 got=%b%b rd=%b exp=0", b1.busy_vec[0], b0.busy_vec[0], b1.rd_busy[1]);
      end
   endtask

   task automatic test_multi_read();
      we0 = 1; wa0 = 2; wd0 = 32'h2222;
      tick();
      idle();
      rd_addr = ports(1, 2, 3, 1);
      #1;
      checks++;
      if (d0(0) !== 32'h1E || d0(1) !== 32'h2222 || d0(2) !== 32'h32 || d0(3) !== 32'h1E) begin
         failures++; $display("FAIL multi_read_nob got=%h %h %h %h exp=1e 2222 32 1e", d0(0), d0(1), d0(2), d0(3));
      end
      checks++;
      if (d1(0) !== 32'h1E || d1(1) !== 32'h2222 || d1(2) !== 32'h32 || d1(3) !== 32'h1E) begin
         failures++; $display("FAIL multi_read_byp got=%h %h %h %h exp=1e 2222 32 1e", d1(0), d1(1), d1(2), d1(3));
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         we0 = 1'($urandom_range(0, 1)); wa0 = rand_addr(); wd0 = $urandom;
         we1 = 1'($urandom_range(0, 1)); wa1 = rand_addr(); wd1 = $urandom;
         iss_valid = 1'($urandom_range(0, 1)); iss_addr = rand_addr();
         for (int k = 0; k < NRD; k++) rd_addr[k*AW +: AW] = rand_addr();
         #1;
         for (int k = 0; k < NRD; k++) begin
            checks++;
            if (d1(k) !== exp_data(rd_addr[k*AW +: AW], 1) || b1.rd_busy[k] !== exp_busy(rd_addr[k*AW +: AW], 1)) begin
               failures++; $display("FAIL rand_byp n=%0d port%0d x%0d got=%h/%b exp=%h/%b", n, k, rd_addr[k*AW +: AW], d1(k), b1.rd_busy[k], exp_data(rd_addr[k*AW +: AW], 1), exp_busy(rd_addr[k*AW +: AW], 1));
            end
            checks++;
            if (d0(k) !== exp_data(rd_addr[k*AW +: AW], 0) || b0.rd_busy[k] !== exp_busy(rd_addr[k*AW +: AW], 0)) begin
               failures++; $display("FAIL rand_nob n=%0d port%0d x%0d got=%h/%b exp=%h/%b", n, k, rd_addr[k*AW +: AW], d0(k), b0.rd_busy[k], exp_data(rd_addr[k*AW +: AW], 0), exp_busy(rd_addr[k*AW +: AW], 0));
            end
         end
         checks++;
         if (b1.busy_vec !== m_busy || b0.busy_vec !== m_busy) begin
            failures++; $display("FAIL rand_busy_vec n=%0d got=%h/%h exp=%h", n, b1.busy_vec, b0.busy_vec, m_busy);
         end
         tick();
      end
      idle();
   endtask

   initial begin
      model_reset();
      idle();
      rd_addr = '0;
      test_reset();
      test_x0_write();
      test_dual_write();
      test_scoreboard();
      test_issue_and_write();
      test_multi_read();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
